// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers.
//   MULTU/MULT use shift-add and DIVU/DIV use restoring division. Each takes
//   W iteration cycles, and signed forms run on magnitudes. The sign fix-up
//   and the HI/LO write happen on the RUN -> FIN edge. MTHI/MTLO write HI/LO
//   directly in the cycle they are accepted.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start, op    operation request, accepted in IDLE or FIN
//                (000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO,
//                 11x no-op)
//   src_a, src_b operands (A: multiplicand/dividend/MTxx data, B: multiplier/divisor)
//   busy         high while iterating (RUN)
//   done         one-cycle pulse when HI/LO hold a new mult/div result (FIN)
//   hi, lo       registered HI/LO
//
// State table
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | iterating, one result bit per cycle, cnt counts down to 0
//   S_FIN  | result in hi/lo, done=1, a new start may be accepted

module mult_div_unit #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [W-1:0] src_a,
   input  logic [W-1:0] src_b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   localparam int             CW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(W - 1);
   localparam logic [2:0]     OP_MTHI  = 3'b100;
   localparam logic [2:0]     OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            is_div;
   logic            div_zero;
   logic            neg_lo;
   logic            neg_hi;
   logic [W-1:0]    opnd;
   logic [W-1:0]    a_raw;
   logic [2*W-1:0]  acc;

   logic            accept;
   logic            acc_md;
   logic            acc_mthi;
   logic            acc_mtlo;
   logic            op_signed;
   logic [W-1:0]    mag_a;
   logic [W-1:0]    mag_b;

   logic [W:0]      mul_sum;
   logic [W:0]      div_shift;
   logic [W:0]      div_diff;
   logic [2*W-1:0]  acc_next;
   logic [2*W-1:0]  prod_fix;
   logic [W-1:0]    quo_fix;
   logic [W-1:0]    rem_fix;
   logic [W-1:0]    fin_hi;
   logic [W-1:0]    fin_lo;

   always_comb begin
      accept    = start && (state != S_RUN);
      acc_md    = accept && (op[2] == 1'b0);
      acc_mthi  = accept && (op == OP_MTHI);
      acc_mtlo  = accept && (op == OP_MTLO);
      op_signed = op[0];
      mag_a     = (op_signed && src_a[W-1]) ? -src_a : src_a;
      mag_b     = (op_signed && src_b[W-1]) ? -src_b : src_b;
   end

   // acc holds {product_hi, multiplier} for mult and {remainder, dividend/quotient}
   // for div. Both shift one bit per cycle, so one register serves both.
   always_comb begin
      mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      div_shift = {acc[2*W-1:W], acc[W-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (is_div) begin
         // Remainder < divisor, so the top bit of the W+1-bit difference is the borrow.
         if (!div_diff[W])
            acc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
         else
            acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      end else begin
         acc_next = {mul_sum, acc[W-1:1]};
      end
   end

   // The final iteration and the sign fix-up share the RUN -> FIN edge.
   always_comb begin
      prod_fix = neg_lo ? -acc_next : acc_next;
      quo_fix  = neg_lo ? -acc_next[W-1:0] : acc_next[W-1:0];
      rem_fix  = neg_hi ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
      if (!is_div) begin
         fin_hi = prod_fix[2*W-1:W];
         fin_lo = prod_fix[W-1:0];
      end else if (div_zero) begin
         fin_hi = a_raw;
         fin_lo = {W{1'b1}};
      end else begin
         fin_hi = rem_fix;
         fin_lo = quo_fix;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         opnd     <= '0;
         a_raw    <= '0;
         acc      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_FIN: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               if (acc_md) begin
                  state    <= S_RUN;
                  busy     <= 1'b1;
                  cnt      <= CNT_LOAD;
                  is_div   <= op[1];
                  div_zero <= (src_b == '0);
                  neg_lo   <= op[0] & (src_a[W-1] ^ src_b[W-1]);
                  neg_hi   <= op[1] & op[0] & src_a[W-1];
                  a_raw    <= src_a;
                  opnd     <= op[1] ? mag_b : mag_a;
                  acc      <= op[1] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
               end
               if (acc_mthi) hi <= src_a;
               if (acc_mtlo) lo <= src_a;
            end
            S_RUN: begin
               acc <= acc_next;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  state <= S_FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= fin_hi;
                  lo    <= fin_lo;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit (W=32): directed vector table, multi-cycle
// corner sequences, and randomized ops against an arithmetic reference model.

module tb_mult_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;

   mult_div_unit #(.W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural meaning of each op.
   function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
      longint sa, sb, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd0: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
         3'd1: begin r = sa * sb; p = r; h = p[63:32]; l = p[31:0]; end
         3'd2: if (b == 0) begin h = a; l = 32'hffffffff; end
               else begin h = a % b; l = a / b; end
         3'd3: if (b == 0) begin h = a; l = 32'hffffffff; end
               else begin
                  r = sa / sb; p = r; l = p[31:0];
                  r = sa % sb; p = r; h = p[31:0];
               end
         3'd4: h = a;
         3'd5: l = a;
         default: ;
      endcase
   endfunction

   // Waits for done after an accepted mult/div; checks latency, HI/LO hold, result.
   task automatic wait_result(input logic [31:0] eh, input logic [31:0] el, input string nm);
      int bc = 0;
      int guard = 0;
      bit hold_ok = 1'b1;
      while (!done && guard < 40) begin
         if (busy) bc++;
         if (hi !== mhi || lo !== mlo) hold_ok = 1'b0;
         @(posedge clk); #1;
         guard++;
      end
      chk({nm, " done"}, {31'h0, done}, 32'd1);
      chk({nm, " busy_cycles"}, bc, 32'd32);
      chk({nm, " hold_in_run"}, {31'h0, hold_ok}, 32'd1);
      chk({nm, " hi"}, hi, eh);
      chk({nm, " lo"}, lo, el);
      mhi = eh;
      mlo = el;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      op    = 3'($urandom());
      src_a = $urandom();
      src_b = $urandom();
      if (o[2] == 1'b0) begin
         wait_result(eh, el, nm);
      end else begin
         chk({nm, " busy"}, {31'h0, busy}, 32'd0);
         chk({nm, " done"}, {31'h0, done}, 32'd0);
         chk({nm, " hi"}, hi, eh);
         chk({nm, " lo"}, lo, el);
         mhi = eh;
         mlo = el;
      end
   endtask

   task automatic check_done_drop(input string nm);
      @(posedge clk); #1;
      chk({nm, " done_one_cycle"}, {31'h0, done}, 32'd0);
      chk({nm, " busy_after"}, {31'h0, busy}, 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hffffffff;
         3: return 32'h80000000;
         4: return 32'h7fffffff;
         default: return $urandom();
      endcase
   endfunction

   vec_t vecs[13];

   initial begin
      int pulses;
      logic [31:0] gh, gl, ra, rb, eh, el;
      logic [2:0] ro;

      vecs[0]  = '{3'd0, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001};
      vecs[1]  = '{3'd1, 32'hfffffffd, 32'h00000007, 32'hffffffff, 32'hffffffeb};
      vecs[2]  = '{3'd3, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd};
      vecs[3]  = '{3'd2, 32'h00000064, 32'h00000000, 32'h00000064, 32'hffffffff};
      vecs[4]  = '{3'd3, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000};
      vecs[5]  = '{3'd4, 32'h12345678, 32'h0000aaaa, 32'h12345678, 32'h80000000};
      vecs[6]  = '{3'd5, 32'hcafef00d, 32'h00005555, 32'h12345678, 32'hcafef00d};
      vecs[7]  = '{3'd6, 32'hdeadbeef, 32'h00000001, 32'h12345678, 32'hcafef00d};
      vecs[8]  = '{3'd7, 32'hffffffff, 32'hffffffff, 32'h12345678, 32'hcafef00d};
      vecs[9]  = '{3'd3, 32'h00000007, 32'hfffffffe, 32'h00000001, 32'hfffffffd};
      vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[11] = '{3'd3, 32'hfffffff9, 32'h00000000, 32'hfffffff9, 32'hffffffff};
      vecs[12] = '{3'd1, 32'h7fffffff, 32'hffffffff, 32'hffffffff, 32'h80000001};

      rst_n = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'h0, busy}, 32'd0);
      chk("reset done", {31'h0, done}, 32'd0);
      chk("reset hi", hi, 32'h0);
      chk("reset lo", lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, $sformatf("vec%0d", i));
      check_done_drop("vec_end");

      // Start during RUN cycle 5 of DIVU 9/4 must be ignored.
      @(negedge clk);
      start = 1'b1; op = 3'd2; src_a = 32'd9; src_b = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 3'd0; src_a = 32'd2; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0; gh = '0; gl = '0;
      for (int c = 0; c < 45; c++) begin
         if (done) begin pulses++; gh = hi; gl = lo; end
         @(posedge clk); #1;
      end
      chk("ignored_start pulses", pulses, 32'd1);
      chk("ignored_start hi", gh, 32'd1);
      chk("ignored_start lo", gl, 32'd2);
      mhi = 32'd1; mlo = 32'd2;

      // Back-to-back starts issued in FIN.
      run_op(3'd0, 32'd2, 32'd3, 32'd0, 32'd6, "b2b0");
      run_op(3'd2, 32'd9, 32'd4, 32'd1, 32'd2, "b2b1");
      run_op(3'd1, 32'hffffffff, 32'hffffffff, 32'd0, 32'd1, "b2b2");
      run_op(3'd4, 32'h0badf00d, 32'd0, 32'h0badf00d, 32'd1, "b2b_mthi");
      check_done_drop("b2b_end");

      // Randomized ops against the reference model.
      for (int i = 0; i < 120; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         eh = mhi; el = mlo;
         ref_op(ro, ra, rb, eh, el);
         run_op(ro, ra, rb, eh, el, $sformatf("rnd%0d_op%0d", i, ro));
      end

      // Reset at RUN cycle 10 discards the operation.
      @(negedge clk);
      start = 1'b1; op = 3'd0; src_a = 32'h1234; src_b = 32'h5678;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_run busy", {31'h0, busy}, 32'd0);
      chk("rst_run done", {31'h0, done}, 32'd0);
      chk("rst_run hi", hi, 32'h0);
      chk("rst_run lo", lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      mhi = '0; mlo = '0;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("rst_run no_done", pulses, 32'd0);

      // Start accepted on the first edge after reset release.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1; op = 3'd0; src_a = 32'd5; src_b = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      chk("post_rst busy", {31'h0, busy}, 32'd1);
      wait_result(32'd0, 32'd30, "post_rst");
      check_done_drop("post_rst_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
